// File: rtl/pipeline_stage_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_stage_sequencer_pkg
//   Shared encodings for the multicycle control sequencer:
//     - STAGE_* : external pipeline_stage encoding consumed by
//                 signal_generation_unit (IF=0, ID=1, EX=2, MEM=3, WB=4,
//                 IDLE=5).
//     - GROUP_* : bit positions in the decoder group vector. LOAD, STORE and
//                 TWO_CYCLE sit above the pre-existing groups.
//     - seq_state_t : internal FSM state, a superset of the stages that adds
//                 IF2 (second fetch word), EX2 (second execute cycle) and
//                 HALT.
//     - seq_ctrl_t / seq_decode() : per-state combinational controls.
// ----------------------------------------------------------------------------
package pipeline_stage_sequencer_pkg;

    // External stage encoding.
    localparam int STAGE_COUNT = 3;

    localparam logic [STAGE_COUNT-1:0] STAGE_IF   = 3'd0;
    localparam logic [STAGE_COUNT-1:0] STAGE_ID   = 3'd1;
    localparam logic [STAGE_COUNT-1:0] STAGE_EX   = 3'd2;
    localparam logic [STAGE_COUNT-1:0] STAGE_MEM  = 3'd3;
    localparam logic [STAGE_COUNT-1:0] STAGE_WB   = 3'd4;
    localparam logic [STAGE_COUNT-1:0] STAGE_IDLE = 3'd5;

    // Decoder group bits. Bits 0..4 are the pre-existing groups; the
    // sequencer only looks at LOAD, STORE and TWO_CYCLE.
    localparam int GROUP_ALU       = 0;
    localparam int GROUP_BRANCH    = 1;
    localparam int GROUP_JUMP      = 2;
    localparam int GROUP_MOVE      = 3;
    localparam int GROUP_SYSTEM    = 4;
    localparam int GROUP_LOAD      = 5;
    localparam int GROUP_STORE     = 6;
    localparam int GROUP_TWO_CYCLE = 7;
    localparam int GROUP_COUNT     = 8;

    // Internal state. 4 bits wide so that unused encodings exist and the
    // recovery path to S_IF is a real piece of logic.
    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_IF2  = 4'd1,
        S_ID   = 4'd2,
        S_EX   = 4'd3,
        S_EX2  = 4'd4,
        S_MEM  = 4'd5,
        S_WB   = 4'd6,
        S_HALT = 4'd7
    } seq_state_t;

    // Controls that are a pure function of the current state.
    typedef struct packed {
        logic [STAGE_COUNT-1:0] stage;
        logic                   instr_ready;
        logic                   mem_req;
        logic                   halted;
        logic                   retire;
    } seq_ctrl_t;

    function automatic seq_ctrl_t seq_decode(input seq_state_t s);
        seq_ctrl_t c;
        c = '{stage: STAGE_IF, instr_ready: 1'b0, mem_req: 1'b0,
              halted: 1'b0, retire: 1'b0};
        case (s)
            S_IF, S_IF2: begin
                c.stage       = STAGE_IF;
                c.instr_ready = 1'b1;
            end
            S_ID:        c.stage = STAGE_ID;
            S_EX, S_EX2: c.stage = STAGE_EX;
            S_MEM: begin
                c.stage   = STAGE_MEM;
                c.mem_req = 1'b1;
            end
            S_WB: begin
                c.stage  = STAGE_WB;
                c.retire = 1'b1;
            end
            S_HALT: begin
                c.stage  = STAGE_IDLE;
                c.halted = 1'b1;
            end
            // Unused encodings look like IF but do not accept a word; the
            // FSM leaves them on the next clock.
            default:     c.stage = STAGE_IF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stage_sequencer_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles spent waiting on data memory. The count restarts from 0
//   whenever clear is high and advances on each enabled cycle. expired is
//   high while the count equals MEM_TIMEOUT-1, meaning the current cycle is
//   the MEM_TIMEOUT-th enabled cycle since the last clear.
//
//   clk      in  clock
//   clear    in  synchronous clear (has priority over enable)
//   enable   in  count this cycle
//   expired  out count has reached MEM_TIMEOUT-1
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    assign expired = (wait_cnt == LAST);

    // Holds at LAST instead of wrapping, so expired stays asserted if the
    // caller keeps the timer enabled past the deadline.
    always_ff @(posedge clk) begin
        if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !expired) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// ----------------------------------------------------------------------------
// pipeline_stage_sequencer
//   Multicycle control FSM. Steps each instruction through
//   IF -> (IF2) -> ID -> EX -> (EX2) -> (MEM) -> WB and reports the stage to
//   signal_generation_unit. Handles the fetch handshake, the data-memory
//   handshake with a wait watchdog, halting at instruction boundaries and a
//   wrapping retired-instruction counter.
//
//   clk             in   clock, all state changes on posedge
//   reset           in   synchronous, active-high
//   instr_valid     in   fetch unit presents a word
//   instr_ready     out  word accepted this cycle (IF/IF2)
//   instr_two_word  in   fetched word is the first half of a 32-bit instr
//   opcode_group    in   decoder group vector, valid during ID
//   mem_ready       in   data memory completed the access
//   mem_req         out  data-memory request (MEM)
//   halt_req        in   stop at the next instruction boundary
//   pipeline_stage  out  stage encoding (STAGE_*)
//   halted          out  high while in HALT
//   retire          out  one-cycle pulse in WB
//   mem_error       out  one-cycle pulse on MEM watchdog abort
//   retired_count   out  retired instruction count, wraps
// ----------------------------------------------------------------------------
module pipeline_stage_sequencer
    import pipeline_stage_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   instr_two_word,
    input  logic [GROUP_COUNT-1:0] opcode_group,
    input  logic                   mem_ready,
    output logic                   mem_req,
    input  logic                   halt_req,
    output logic [STAGE_COUNT-1:0] pipeline_stage,
    output logic                   halted,
    output logic                   retire,
    output logic                   mem_error,
    output logic [RET_W-1:0]       retired_count
);

    seq_state_t             state;
    logic [GROUP_COUNT-1:0] grp_q;
    logic                   two_q;
    seq_ctrl_t              ctrl;
    logic                   tmr_clear;
    logic                   tmr_en;
    logic                   tmr_expired;
    logic                   is_mem_op;
    logic                   mem_abort;

    // Only the load/store/two-cycle groups steer the sequencer; the rest of
    // the latched vector is kept for symmetry with the decoder.
    logic unused_grp;
    assign unused_grp = ^{grp_q[GROUP_SYSTEM:GROUP_ALU]};

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    assign ctrl           = seq_decode(state);
    assign pipeline_stage = ctrl.stage;
    assign instr_ready    = ctrl.instr_ready;
    assign mem_req        = ctrl.mem_req;
    assign halted         = ctrl.halted;
    assign retire         = ctrl.retire;

    assign is_mem_op = grp_q[GROUP_LOAD] | grp_q[GROUP_STORE];

    // mem_ready beats the watchdog when both land in the same cycle.
    assign mem_abort = (state == S_MEM) && tmr_expired && !mem_ready;
    assign mem_error = mem_abort;

    // ------------------------------------------------------------------
    // Memory wait watchdog: cleared outside MEM so every MEM visit starts
    // counting from 0.
    // ------------------------------------------------------------------
    assign tmr_clear = reset || (state != S_MEM);
    assign tmr_en    = (state == S_MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM, group/two-word latches and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IF;
            grp_q         <= '0;
            two_q         <= 1'b0;
            retired_count <= '0;
        end else begin
            case (state)
                S_IF: begin
                    if (instr_valid) begin
                        two_q <= instr_two_word;
                        state <= instr_two_word ? S_IF2 : S_ID;
                    end
                end

                // Second half of a 32-bit instruction. IF2 is only reachable
                // with two_q set; anything else is treated as corruption and
                // refetched.
                S_IF2: begin
                    if (!two_q) begin
                        state <= S_IF;
                    end else if (instr_valid) begin
                        state <= S_ID;
                    end
                end

                // The decoder output is only valid here, so capture it.
                S_ID: begin
                    grp_q <= opcode_group;
                    state <= S_EX;
                end

                S_EX: begin
                    if (grp_q[GROUP_TWO_CYCLE]) begin
                        state <= S_EX2;
                    end else if (is_mem_op) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end

                S_EX2: begin
                    state <= is_mem_op ? S_MEM : S_WB;
                end

                // Aborted accesses drop the instruction without retiring.
                S_MEM: begin
                    if (mem_ready) begin
                        state <= S_WB;
                    end else if (tmr_expired) begin
                        state <= S_IF;
                    end
                end

                // halt_req is only looked at here, so a request raised
                // mid-instruction always lets that instruction finish.
                S_WB: begin
                    retired_count <= retired_count + RET_W'(1);
                    state         <= halt_req ? S_HALT : S_IF;
                end

                S_HALT: begin
                    if (!halt_req) begin
                        state <= S_IF;
                    end
                end

                default: state <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
module tb_pipeline_stage_sequencer;
    import pipeline_stage_sequencer_pkg::*;

    localparam int RET_W = 8;

    logic                   clk;
    logic                   reset;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   instr_two_word;
    logic [GROUP_COUNT-1:0] opcode_group;
    logic                   mem_ready;
    logic                   mem_req;
    logic                   halt_req;
    logic [STAGE_COUNT-1:0] pipeline_stage;
    logic                   halted;
    logic                   retire;
    logic                   mem_error;
    logic [RET_W-1:0]       retired_count;

    pipeline_stage_sequencer #(
        .MEM_TIMEOUT (16),
        .RET_W       (RET_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_two_word (instr_two_word),
        .opcode_group   (opcode_group),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .halt_req       (halt_req),
        .pipeline_stage (pipeline_stage),
        .halted         (halted),
        .retire         (retire),
        .mem_error      (mem_error),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;   // {stage[2:0], ready, mem_req, retire, mem_error, halted}
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [7:0] G_ALU   = 8'(1) << GROUP_ALU;
    localparam logic [7:0] G_LOAD  = 8'(1) << GROUP_LOAD;
    localparam logic [7:0] G_STORE = 8'(1) << GROUP_STORE;
    localparam logic [7:0] G_TWO   = 8'(1) << GROUP_TWO_CYCLE;

    // One clock cycle: drive inputs, queue the expected outputs for this
    // cycle, compare at the falling edge, then advance past the rising edge.
    task automatic cyc(input logic iv, input logic tw, input logic mr,
                       input logic hr, input logic [7:0] grp,
                       input logic [2:0] stg, input logic rdy, input logic mrq,
                       input logic ret, input logic merr, input logic hlt,
                       input string tag);
        exp_t e;
        logic [7:0] obs;
        instr_valid    = iv;
        instr_two_word = tw;
        mem_ready      = mr;
        halt_req       = hr;
        opcode_group   = grp;
        e.v   = {stg, rdy, mrq, ret, merr, hlt};
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
        e   = q.pop_front();
        obs = {pipeline_stage, instr_ready, mem_req, retire, mem_error, halted};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: got stg/rdy/mreq/ret/merr/hlt=%b want %b", e.tag, obs, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input logic [RET_W-1:0] want, input string tag);
        checks++;
        assert (retired_count === want) else begin
            errors++;
            $error("FAIL %s: retired_count got %0d want %0d", tag, retired_count, want);
        end
    endtask

    // ALU instruction, instr_valid held high throughout: IF, ID, EX, WB.
    task automatic alu_op(input string tag);
        cyc(1, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, {tag, "_if"});
        cyc(1, 0, 0, 0, G_ALU, STAGE_ID, 0, 0, 0, 0, 0, {tag, "_id"});
        cyc(1, 0, 0, 0, 8'h00, STAGE_EX, 0, 0, 0, 0, 0, {tag, "_ex"});
        cyc(1, 0, 0, 0, 8'h00, STAGE_WB, 0, 0, 1, 0, 0, {tag, "_wb"});
    endtask

    initial begin
        reset = 1'b1; instr_valid = 0; instr_two_word = 0; opcode_group = '0;
        mem_ready = 0; halt_req = 0;
        @(posedge clk); #1;

        // Reset state (reset still high this cycle).
        cyc(0, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "rst_state");
        chk_cnt(0, "rst_count");
        reset = 1'b0;

        // 1: single ALU op.
        alu_op("t1");
        chk_cnt(1, "t1_count");

        // 2: load, mem_ready in the third MEM cycle.
        cyc(1, 0, 0, 0, 8'h00,  STAGE_IF,  1, 0, 0, 0, 0, "t2_if");
        cyc(0, 0, 0, 0, G_LOAD, STAGE_ID,  0, 0, 0, 0, 0, "t2_id");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_EX,  0, 0, 0, 0, 0, "t2_ex");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_MEM, 0, 1, 0, 0, 0, "t2_mem1");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_MEM, 0, 1, 0, 0, 0, "t2_mem2");
        cyc(0, 0, 1, 0, 8'h00,  STAGE_MEM, 0, 1, 0, 0, 0, "t2_mem3");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_WB,  0, 0, 1, 0, 0, "t2_wb");
        chk_cnt(2, "t2_count");

        // 3: load with no mem_ready; watchdog fires in the 16th MEM cycle.
        cyc(1, 0, 0, 0, 8'h00,  STAGE_IF, 1, 0, 0, 0, 0, "t3_if");
        cyc(0, 0, 0, 0, G_LOAD, STAGE_ID, 0, 0, 0, 0, 0, "t3_id");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_EX, 0, 0, 0, 0, 0, "t3_ex");
        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 0, 8'h00, STAGE_MEM, 0, 1, 0, (i == 15), 0,
                $sformatf("t3_mem%0d", i + 1));
        cyc(0, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t3_after");
        chk_cnt(2, "t3_count");

        // 4: two-word, two-cycle store with a 2-cycle gap between words.
        cyc(1, 1, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t4_if");
        cyc(0, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t4_gap1");
        cyc(0, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t4_gap2");
        cyc(1, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t4_if2");
        cyc(0, 0, 0, 0, G_STORE | G_TWO, STAGE_ID, 0, 0, 0, 0, 0, "t4_id");
        cyc(0, 0, 0, 0, 8'h00, STAGE_EX,  0, 0, 0, 0, 0, "t4_ex");
        cyc(0, 0, 0, 0, 8'h00, STAGE_EX,  0, 0, 0, 0, 0, "t4_ex2");
        cyc(0, 0, 1, 0, 8'h00, STAGE_MEM, 0, 1, 0, 0, 0, "t4_mem");
        cyc(0, 0, 0, 0, 8'h00, STAGE_WB,  0, 0, 1, 0, 0, "t4_wb");
        chk_cnt(3, "t4_count");

        // 5a: halt_req raised in EX and held 5 cycles.
        cyc(1, 0, 0, 0, 8'h00, STAGE_IF,   1, 0, 0, 0, 0, "t5_if");
        cyc(0, 0, 0, 0, G_ALU, STAGE_ID,   0, 0, 0, 0, 0, "t5_id");
        cyc(0, 0, 0, 1, 8'h00, STAGE_EX,   0, 0, 0, 0, 0, "t5_ex");
        cyc(0, 0, 0, 1, 8'h00, STAGE_WB,   0, 0, 1, 0, 0, "t5_wb");
        cyc(0, 0, 0, 1, 8'h00, STAGE_IDLE, 0, 0, 0, 0, 1, "t5_halt1");
        cyc(1, 0, 0, 1, 8'h00, STAGE_IDLE, 0, 0, 0, 0, 1, "t5_halt2");
        cyc(1, 0, 0, 1, 8'h00, STAGE_IDLE, 0, 0, 0, 0, 1, "t5_halt3");
        cyc(0, 0, 0, 0, 8'h00, STAGE_IDLE, 0, 0, 0, 0, 1, "t5_release");
        cyc(0, 0, 0, 0, 8'h00, STAGE_IF,   1, 0, 0, 0, 0, "t5_resume");
        chk_cnt(4, "t5_count");

        // 5b: halt_req pulsed in ID, gone by WB -> no halt.
        cyc(1, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t5b_if");
        cyc(0, 0, 0, 1, G_ALU, STAGE_ID, 0, 0, 0, 0, 0, "t5b_id");
        cyc(0, 0, 0, 0, 8'h00, STAGE_EX, 0, 0, 0, 0, 0, "t5b_ex");
        cyc(0, 0, 0, 0, 8'h00, STAGE_WB, 0, 0, 1, 0, 0, "t5b_wb");
        cyc(0, 0, 0, 0, 8'h00, STAGE_IF, 1, 0, 0, 0, 0, "t5b_nohalt");
        chk_cnt(5, "t5b_count");

        // 6a: reset while in MEM abandons the instruction and clears count.
        cyc(1, 0, 0, 0, 8'h00,  STAGE_IF,  1, 0, 0, 0, 0, "t6_if");
        cyc(0, 0, 0, 0, G_LOAD, STAGE_ID,  0, 0, 0, 0, 0, "t6_id");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_EX,  0, 0, 0, 0, 0, "t6_ex");
        cyc(0, 0, 0, 0, 8'h00,  STAGE_MEM, 0, 1, 0, 0, 0, "t6_mem1");
        reset = 1'b1;
        cyc(0, 0, 1, 0, 8'h00,  STAGE_MEM, 0, 1, 0, 0, 0, "t6_mem_rst");
        reset = 1'b0;
        cyc(0, 0, 0, 0, 8'h00,  STAGE_IF,  1, 0, 0, 0, 0, "t6_after_rst");
        chk_cnt(0, "t6_count_clr");

        // 6b: counter wrap (RET_W=8): 255 retires, then one more wraps to 0.
        for (int i = 0; i < 255; i++) alu_op("t6w");
        chk_cnt(8'hFF, "t6_count_ff");
        alu_op("t6last");
        chk_cnt(8'h00, "t6_count_wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
